// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequence controller and its step function.
package lfsr_pkg;

  localparam int          LFSR_W        = 16;
  localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_RUN     = 2'd1,
    OP_MEASURE = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_step.sv
// One step of a right-shifting Galois LFSR: shift down, fold TAPS in when the lsb falls out.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven controller around a Galois LFSR: seed load, word streaming, period measurement.
//
// state  | meaning
// S_IDLE | waiting for a command; LOAD/reserved/zero-count RUN complete here
// S_RUN  | streaming lfsr words over out_valid/out_ready until count expires
// S_MEAS | stepping once per cycle until the sequence returns to s0
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF
) (
  input  logic             CLK,
  input  logic             n_RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH:0] MEAS_LIMIT = (WIDTH+1)'(1) << WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH:0]   meas_q, meas_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      count_q  <= '0;
      s0_q     <= '0;
      meas_q   <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      s0_q     <= s0_d;
      meas_q   <= meas_d;
      period_q <= period_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    s0_d     = s0_q;
    meas_d   = meas_q;
    period_d = period_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          case (op_e'(cmd_op))
            OP_LOAD: begin
              done_d = 1'b1;
              // all-zero is the lockup state of the register, so refuse it
              if (cmd_arg != '0) lfsr_d = cmd_arg;
              else               err_d  = 1'b1;
            end
            OP_RUN: begin
              count_d = cmd_arg;
              if (cmd_arg == '0) done_d  = 1'b1;
              else               state_d = S_RUN;
            end
            OP_MEASURE: begin
              s0_d    = lfsr_q;
              meas_d  = '0;
              state_d = S_MEAS;
            end
            default: begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          lfsr_d  = lfsr_nxt;
          count_d = count_q - WIDTH'(1);
          if (count_q == WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_MEAS: begin
        if (abort) begin
          lfsr_d  = s0_q;
          state_d = S_IDLE;
        end else if (lfsr_nxt == s0_q) begin
          period_d = meas_q[WIDTH-1:0] + WIDTH'(1);
          lfsr_d   = s0_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (meas_q == MEAS_LIMIT) begin
          err_d    = 1'b1;
          period_d = '0;
          lfsr_d   = s0_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          lfsr_d = lfsr_nxt;
          meas_d = meas_q + (WIDTH+1)'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RUN);
  assign out_data  = lfsr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign period    = period_q;

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Command-driven controller around a 16-bit Galois LFSR, the team's pseudo-random source.
- Loads a seed and streams a requested number of LFSR words over a valid/ready output port.
- Measures the sequence period and reports it.
- Sits between a host command interface and downstream consumers (pattern generators, scramblers).

Parameters:
- WIDTH, 16, LFSR and data width.
- TAPS, 16'hB400, Galois feedback mask (maximal-length, x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1, LFSR value after reset.

Ports:
- CLK  input  1  system clock, rising edge
- n_RESET  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller accepts a command (high only in IDLE)
- cmd_op  input  2  0=LOAD, 1=RUN, 2=MEASURE, 3=reserved
- cmd_arg  input  WIDTH  seed for LOAD; word count for RUN; ignored otherwise
- abort  input  1  synchronous abort of RUN/MEASURE
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  WIDTH  current LFSR state
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse on normal completion of any command
- err  output  1  sticky error flag; cleared by the next accepted command
- period  output  WIDTH  result of the last MEASURE; 0 on error

Behaviour:
- Reset: this block uses one clock; reset is asynchronous and active-low.
- Reset values: lfsr=SEED, state=IDLE, out_valid=0, busy=0, done=0, err=0, period=0, count=0.
- Step function: lsb=lfsr[0]; next=lfsr>>1; if lsb then next^=TAPS.
- Command accept: cmd_valid&&cmd_ready in IDLE. err clears in the same cycle.
- LOAD:
  - cmd_arg!=0: lfsr<=cmd_arg; done pulses next cycle.
  - cmd_arg==0 (lockup value): lfsr unchanged, err<=1, done pulses.
  - Stays in IDLE.
- RUN:
  - count<=cmd_arg; go to RUN.
  - cmd_arg==0: no words are emitted; done pulses next cycle; returns to IDLE.
- RUN state:
  - out_valid=1 and out_data=lfsr. The first word is the current lfsr value, not its successor.
  - On out_valid&&out_ready: lfsr<=step(lfsr), count<=count-1.
  - On the handshake where count==1: go to IDLE and pulse done in the following cycle.
  - out_data holds stable while out_valid&&!out_ready.
- MEASURE:
  - On accept: save s0<=lfsr, clear the 17-bit step counter, go to MEAS.
- MEAS state:
  - One step per cycle; counter increments each step.
  - When step(lfsr)==s0: period<=counter+1, lfsr<=s0, done, go to IDLE.
  - If the counter reaches 2^16 with no match: err<=1, period<=0, lfsr<=s0, done, go to IDLE.
  - out_valid=0 throughout.
- abort:
  - Sampled every cycle; ignored in IDLE.
  - In RUN: go to IDLE next cycle, lfsr holds, no done pulse.
  - In MEAS: lfsr<=s0, period unchanged, no done pulse.
  - abort has priority over completion in the same cycle.
- Reserved op: accepted, err<=1, done pulses.
- Reset mid-operation: all state returns to reset values immediately; any partial RUN/MEASURE is discarded.
- busy=(state!=IDLE). done is never high while busy is high, except the completion pulse cycle, which is in IDLE.

Decomposition:
- Package lfsr_pkg holds:
  - op enum (OP_LOAD, OP_RUN, OP_MEASURE, OP_RSVD);
  - FSM state enum (S_IDLE, S_RUN, S_MEAS);
  - constants LFSR_W=16, LFSR_TAPS_DEF=16'hB400, LFSR_SEED_DEF=16'hACE1.
- Sub-module lfsr_step: purely combinational next-state function, parameterised by WIDTH/TAPS. It is reused by lfsr_seq_ctrl and its scoreboard model.

Test Plan:
- Reset, then RUN count=3 with out_ready=1 -> out_data ACE1, E270, 7138 on three consecutive cycles; done one cycle after the last handshake; busy low afterwards.
- RUN count=2 with out_ready toggling 0,1,0,0,1 -> out_data holds ACE1 until the first accept, then E270; exactly 2 handshakes; done once.
- MEASURE from reset -> done after 65535 step cycles; period=16'hFFFF; err=0; lfsr back to ACE1 (next RUN count=1 emits ACE1).
- LOAD cmd_arg=0 -> err=1, lfsr unchanged (next RUN count=1 emits ACE1). Then LOAD 16'h0001 -> err clears and the next RUN emits 0001, B400.
- RUN count=100, abort after 5 handshakes -> IDLE next cycle, no done; next RUN count=1 emits the 6th sequence value.
- n_RESET asserted mid-MEASURE -> outputs drop to reset values asynchronously; after release, RUN count=1 emits ACE1.
